// File: rtl/fpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : fpu_pkg                                                          |
// | Shared types and constants for the FPU issue/writeback sequencer:          |
// | sequencer state encoding, FPU control bit positions, flag bit positions    |
// | and the all-ones exponent patterns used to detect Inf/NaN results.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package fpu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_e;

   // FPU control word bit positions
   localparam int OP_MUL = 1;
   localparam int FMT_32 = 0;

   // Writeback flag bit positions, {N,Z,C,V}
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   localparam logic [7:0] EXP32_ONES = 8'hFF;
   localparam logic [4:0] EXP16_ONES = 5'h1F;

endpackage
`default_nettype wire

// File: rtl/fpu_flag_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fpu_flag_gen                                                     |
// | Combinational {N,Z,C,V} flag derivation from an FPU result word.           |
// | Ports   : result_i  [31:0] result (fp16 in [15:0], upper bits ignored)     |
// |           fmt32_i          1 = fp32 result, 0 = fp16 result                |
// |           flags_o   [3:0]  {N,Z,C,V}                                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fpu_flag_gen
   import fpu_pkg::*;
(
   input  logic [31:0] result_i,
   input  logic        fmt32_i,
   output logic [3:0]  flags_o
);

   // Z ignores the sign bit, so -0 reports both N and Z.
   // V flags an all-ones exponent (Inf or NaN).
   always_comb begin
      flags_o = 4'b0000;
      if (fmt32_i) begin
         flags_o[FLAG_N] = result_i[31];
         flags_o[FLAG_Z] = (result_i[30:0] == 31'd0);
         flags_o[FLAG_V] = (result_i[30:23] == EXP32_ONES);
      end else begin
         flags_o[FLAG_N] = result_i[15];
         flags_o[FLAG_Z] = (result_i[14:0] == 15'd0);
         flags_o[FLAG_V] = (result_i[14:10] == EXP16_ONES);
      end
      flags_o[FLAG_C] = 1'b0;
   end

endmodule
`default_nettype wire

// File: rtl/fpu_issue_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fpu_issue_seq                                                    |
// | Multicycle issue/writeback sequencer around a combinational fp32/fp16 FPU. |
// | Holds operands on the FPU for LAT32/LAT16 cycles, then captures result and |
// | flags into a single writeback slot with valid/ready handshake.             |
// | Ports   : clk, reset (sync, active-low), flush (sync abort)                |
// |           req_*  : request handshake, operands, control, destination       |
// |           fpu_*  : operands/control to FPU, fpu_result back               |
// |           wb_*   : writeback slot handshake, rd, result, {N,Z,C,V} flags   |
// |           busy   : sequencer not idle                                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fpu_issue_seq
   import fpu_pkg::*;
#(
   parameter int LAT32 = 3,
   parameter int LAT16 = 2,
   parameter int RD_W  = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [31:0]     req_a,
   input  logic [31:0]     req_b,
   input  logic [1:0]      req_ctrl,
   input  logic [RD_W-1:0] req_rd,
   output logic [31:0]     fpu_a,
   output logic [31:0]     fpu_b,
   output logic [1:0]      fpu_ctrl,
   input  logic [31:0]     fpu_result,
   output logic            wb_valid,
   input  logic            wb_ready,
   output logic [RD_W-1:0] wb_rd,
   output logic [31:0]     wb_result,
   output logic [3:0]      wb_flags,
   output logic            busy
);

   localparam int LAT_MAX = (LAT32 > LAT16) ? LAT32 : LAT16;
   localparam int CNT_W   = $clog2(LAT_MAX) + 1;
   localparam logic [CNT_W-1:0] CNT32_INIT = CNT_W'(LAT32 - 1);
   localparam logic [CNT_W-1:0] CNT16_INIT = CNT_W'(LAT16 - 1);

   state_e          state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [31:0]     fpu_a_q;
   logic [31:0]     fpu_b_q;
   logic [1:0]      fpu_ctrl_q;
   logic [RD_W-1:0] rd_q;
   logic            wb_valid_q;
   logic [31:0]     wb_result_q;
   logic [3:0]      wb_flags_q;

   logic            accept;
   logic [31:0]     cap_result_d;
   logic [3:0]      cap_flags_d;

   // Ready in IDLE, or in DONE when the slot is being drained this cycle so a
   // new op can start on the same edge. Flush and reset block any acceptance.
   assign req_ready = reset && !flush &&
                      ((state_q == IDLE) || ((state_q == DONE) && wb_ready));
   assign accept    = req_valid && req_ready;

   // fp16 results are forced to a clean zero-extended form regardless of what
   // the FPU drives on the upper half.
   assign cap_result_d = fpu_ctrl_q[FMT_32] ? fpu_result
                                            : {16'h0000, fpu_result[15:0]};

   fpu_flag_gen u_flag_gen (
      .result_i (cap_result_d),
      .fmt32_i  (fpu_ctrl_q[FMT_32]),
      .flags_o  (cap_flags_d)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         fpu_a_q     <= '0;
         fpu_b_q     <= '0;
         fpu_ctrl_q  <= '0;
         rd_q        <= '0;
         wb_valid_q  <= 1'b0;
         wb_result_q <= '0;
         wb_flags_q  <= '0;
      end else if (flush) begin
         // Drop any in-flight or pending result; FPU inputs keep last values.
         state_q    <= IDLE;
         cnt_q      <= '0;
         wb_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: ;
            EXEC: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end else begin
                  wb_result_q <= cap_result_d;
                  wb_flags_q  <= cap_flags_d;
                  wb_valid_q  <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (wb_ready) begin
                  wb_valid_q <= 1'b0;
                  state_q    <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase

         // Acceptance overrides the DONE->IDLE move for back-to-back issue.
         if (accept) begin
            fpu_a_q    <= req_a;
            fpu_b_q    <= req_b;
            fpu_ctrl_q <= req_ctrl;
            rd_q       <= req_rd;
            cnt_q      <= req_ctrl[FMT_32] ? CNT32_INIT : CNT16_INIT;
            state_q    <= EXEC;
         end
      end
   end

   assign fpu_a     = fpu_a_q;
   assign fpu_b     = fpu_b_q;
   assign fpu_ctrl  = fpu_ctrl_q;
   assign wb_valid  = wb_valid_q;
   assign wb_rd     = rd_q;
   assign wb_result = wb_result_q;
   assign wb_flags  = wb_flags_q;
   assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fpu_issue_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_fpu_issue_seq                                                 |
// | Self-checking bench for fpu_issue_seq with a table-driven FPU stand-in.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fpu_issue_seq;

   localparam int LAT32_TB = 3;
   localparam int LAT16_TB = 2;
   localparam int NTBL     = 5;

   // Known FPU vectors: a, b, ctrl, result, flags {N,Z,C,V}
   localparam logic [31:0] TA [NTBL] = '{32'h3F800000, 32'h40000000, 32'h00003C00, 32'h3F800000, 32'h7F7FFFFF};
   localparam logic [31:0] TB [NTBL] = '{32'h40000000, 32'hC0400000, 32'h00003C00, 32'hBF800000, 32'h40000000};
   localparam logic [1:0]  TC [NTBL] = '{2'b01, 2'b11, 2'b00, 2'b01, 2'b11};
   localparam logic [31:0] TR [NTBL] = '{32'h40400000, 32'hC0C00000, 32'h00004000, 32'h00000000, 32'h7F800000};
   localparam logic [3:0]  TF [NTBL] = '{4'b0000, 4'b1000, 4'b0000, 4'b0100, 4'b0001};

   localparam logic [31:0] POOL [8] = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800001,
                                        32'h00007C00, 32'h00008000, 32'h0000FC00, 32'h12345678};

   logic        clk = 1'b0;
   logic        reset, flush, req_valid, req_ready, wb_valid, wb_ready, busy;
   logic [31:0] req_a, req_b, fpu_a, fpu_b, fpu_result, wb_result;
   logic [1:0]  req_ctrl, fpu_ctrl;
   logic [3:0]  req_rd, wb_rd, wb_flags;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] res;
      logic [3:0]  flags;
      logic [3:0]  rd;
      int          lat;
      int          acc;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   fpu_issue_seq #(.LAT32(LAT32_TB), .LAT16(LAT16_TB), .RD_W(4)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl), .req_rd(req_rd),
      .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_ctrl(fpu_ctrl), .fpu_result(fpu_result),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
      .wb_result(wb_result), .wb_flags(wb_flags), .busy(busy)
   );

   function automatic int tbl_idx(logic [31:0] a, logic [31:0] b, logic [1:0] c);
      for (int i = 0; i < NTBL; i++)
         if (TA[i] == a && TB[i] == b && TC[i] == c) return i;
      return -1;
   endfunction

   // FPU stand-in: exact results for known vectors, otherwise a deterministic
   // scramble; fp16 results carry junk in the upper half on purpose.
   function automatic logic [31:0] mock_fpu(logic [31:0] a, logic [31:0] b, logic [1:0] c);
      int k;
      logic [31:0] m;
      k = tbl_idx(a, b, c);
      if (k >= 0) return TR[k];
      m = c[1] ? (a ^ {b[15:0], b[31:16]}) : (a ^ b);
      if (c[0]) return m;
      return {16'hA5A5, m[15:0]};
   endfunction

   always_comb fpu_result = mock_fpu(fpu_a, fpu_b, fpu_ctrl);

   function automatic logic [3:0] ref_flags(logic [31:0] r, logic is32);
      logic [31:0] e;
      logic n, z, v;
      if (is32) begin
         n = r[31];
         z = ((r & 32'h7FFFFFFF) == 32'd0);
         e = (r >> 23) & 32'd255;
         v = (e == 32'd255);
      end else begin
         n = r[15];
         z = ((r & 32'h00007FFF) == 32'd0);
         e = (r >> 10) & 32'd31;
         v = (e == 32'd31);
      end
      return {n, z, 1'b0, v};
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial begin : monitor
      int  cyc;
      bit  prev_rst_low;
      bit  e_busy, e_wbv, e_rdy;
      exp_t e;
      int  k;
      logic [31:0] r;
      cyc = 0;
      prev_rst_low = 1'b0;
      @(posedge clk);
      forever begin
         @(negedge clk);
         cyc++;
         e_busy = (sb.size() != 0);
         e_wbv  = e_busy && ((cyc - sb[0].acc) >= (sb[0].lat + 1));
         e_rdy  = reset && !flush && (!e_busy || (e_wbv && wb_ready));
         chk("busy", {31'd0, busy}, {31'd0, e_busy});
         chk("wb_valid", {31'd0, wb_valid}, {31'd0, e_wbv});
         chk("req_ready", {31'd0, req_ready}, {31'd0, e_rdy});
         if (e_wbv && wb_valid) begin
            chk("wb_result", wb_result, sb[0].res);
            chk("wb_flags", {28'd0, wb_flags}, {28'd0, sb[0].flags});
            chk("wb_rd", {28'd0, wb_rd}, {28'd0, sb[0].rd});
         end
         if (prev_rst_low) begin
            chk("rst_fpu_a", fpu_a, 32'd0);
            chk("rst_fpu_b", fpu_b, 32'd0);
            chk("rst_fpu_ctrl", {30'd0, fpu_ctrl}, 32'd0);
            chk("rst_wb_result", wb_result, 32'd0);
            chk("rst_wb_flags", {28'd0, wb_flags}, 32'd0);
            chk("rst_wb_rd", {28'd0, wb_rd}, 32'd0);
         end
         // Model what the coming edge does.
         if (!reset || flush) begin
            sb.delete();
         end else begin
            if (e_wbv && wb_ready) void'(sb.pop_front());
            if (req_valid && e_rdy) begin
               k = tbl_idx(req_a, req_b, req_ctrl);
               r = mock_fpu(req_a, req_b, req_ctrl);
               if (!req_ctrl[0]) r = r & 32'h0000FFFF;
               e.res   = r;
               e.flags = (k >= 0) ? TF[k] : ref_flags(r, req_ctrl[0]);
               e.rd    = req_rd;
               e.lat   = req_ctrl[0] ? LAT32_TB : LAT16_TB;
               e.acc   = cyc;
               sb.push_back(e);
            end
         end
         prev_rst_low = !reset;
      end
   end

   // ---------------- driver ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(logic [31:0] a, logic [31:0] b, logic [1:0] c, logic [3:0] rd);
      bit ok;
      ok = 1'b0;
      req_a = a; req_b = b; req_ctrl = c; req_rd = rd; req_valid = 1'b1;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (req_ready) ok = 1'b1;
      end
      step();
      req_valid = 1'b0;
      if (!ok) begin
         failures++;
         $display("FAIL issue_timeout: req_ready never rose for a=%h", a);
      end
   endtask

   task automatic wait_wb();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (wb_valid) ok = 1'b1;
      end
      if (!ok) begin
         failures++;
         $display("FAIL wb_timeout: wb_valid never rose");
      end
   endtask

   task automatic pick_operands();
      int s;
      s = $urandom_range(0, 7);
      if (s < 2) begin
         s = $urandom_range(0, NTBL - 1);
         req_a = TA[s]; req_b = TB[s]; req_ctrl = TC[s];
      end else begin
         req_a    = ($urandom_range(0, 1) == 0) ? POOL[$urandom_range(0, 7)] : $urandom;
         req_b    = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
         req_ctrl = 2'($urandom_range(0, 3));
      end
      req_rd = 4'($urandom_range(0, 15));
   endtask

   initial begin : driver
      reset = 1'b0; flush = 1'b0; req_valid = 1'b0; wb_ready = 1'b1;
      req_a = '0; req_b = '0; req_ctrl = '0; req_rd = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      step();

      // Directed vectors, drained immediately.
      for (int i = 0; i < NTBL; i++) begin
         issue(TA[i], TB[i], TC[i], 4'(i + 1));
         wait_wb();
         step();
      end

      // Back-pressure in DONE with a pending request, then back-to-back issue.
      wb_ready = 1'b0;
      issue(TA[0], TB[0], TC[0], 4'd7);
      wait_wb();
      step();
      req_a = TA[1]; req_b = TB[1]; req_ctrl = TC[1]; req_rd = 4'd8; req_valid = 1'b1;
      repeat (5) step();
      wb_ready = 1'b1;
      issue(TA[1], TB[1], TC[1], 4'd8);
      wait_wb();
      step();

      // Flush in the second EXEC cycle while a new request is offered.
      issue(TA[0], TB[0], TC[0], 4'd3);
      step();
      flush = 1'b1;
      req_a = TA[2]; req_b = TB[2]; req_ctrl = TC[2]; req_rd = 4'd9; req_valid = 1'b1;
      step();
      flush = 1'b0; req_valid = 1'b0;
      repeat (6) step();

      // Reset during EXEC.
      issue(TA[1], TB[1], TC[1], 4'd5);
      reset = 1'b0;
      step();
      reset = 1'b1;
      repeat (3) step();

      // Reset during DONE.
      wb_ready = 1'b0;
      issue(TA[4], TB[4], TC[4], 4'd6);
      wait_wb();
      step();
      reset = 1'b0;
      step();
      reset = 1'b1; wb_ready = 1'b1;
      repeat (3) step();

      // Randomised traffic.
      for (int n = 0; n < 3000; n++) begin
         reset     = ($urandom_range(0, 199) != 0);
         flush     = ($urandom_range(0, 24) == 0);
         req_valid = ($urandom_range(0, 1) == 1);
         wb_ready  = ($urandom_range(0, 3) != 0);
         pick_operands();
         step();
      end
      reset = 1'b1; flush = 1'b0; req_valid = 1'b0; wb_ready = 1'b1;
      repeat (10) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
